// File: rtl/regfile_scrub.sv
// Two-read/one-write register file with optional r0-is-zero, write-to-read forwarding,
// and a sequential zeroing engine that runs after reset and on clear_req.
module regfile_scrub #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] rdaddress_a,
  input  logic [ADDR_W-1:0] rdaddress_b,
  input  logic              wren,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic [DATA_W-1:0] data,
  input  logic              clear_req,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, SCRUB} state_t;

  state_t                       state_reg, state_next;
  logic [ADDR_W-1:0]            cnt_reg, cnt_next;
  logic [1:0][DATA_W-1:0]       q_reg, q_next;
  logic [1:0][ADDR_W-1:0]       rd_addr;
  logic [1:0][DATA_W-1:0]       rd_data;
  logic [DATA_W-1:0]            mem [DEPTH];
  logic                         port_wr;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_waddr;
  logic [DATA_W-1:0]            mem_wdata;

  assign rd_addr[0] = rdaddress_a;
  assign rd_addr[1] = rdaddress_b;

  // Port write is live only in IDLE, enabled, and not on a clear edge.
  assign port_wr = (state_reg == IDLE) && !clear_req && enable && wren;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read_port
      assign rd_data[gi] =
          (ZERO_R0 != 0 && rd_addr[gi] == '0)              ? '0   :
          (BYPASS != 0 && port_wr && rd_addr[gi] == wraddress) ? data :
                                                               mem[rd_addr[gi]];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    mem_we     = 1'b0;
    mem_waddr  = wraddress;
    mem_wdata  = data;
    case (state_reg)
      IDLE: begin
        if (clear_req) begin
          state_next = SCRUB;
          cnt_next   = '0;
          q_next     = '0;
        end else if (enable) begin
          q_next = rd_data;
          mem_we = wren && !(ZERO_R0 != 0 && wraddress == '0);
        end
      end
      SCRUB: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg;
        mem_wdata = '0;
        cnt_next  = cnt_reg + 1'b1;
        q_next    = '0;
        if (cnt_reg == ADDR_W'(DEPTH - 1))
          state_next = IDLE;
      end
      default: state_next = SCRUB;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= SCRUB;
      cnt_reg   <= '0;
      q_reg     <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
    end
  end

  // Array kept free of reset so it maps onto RAM; reset only suppresses the write.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  assign qa   = q_reg[0];
  assign qb   = q_reg[1];
  assign busy = (state_reg == SCRUB);

endmodule

// File: tb/tb_regfile_scrub.sv
// Randomized scoreboard bench for regfile_scrub: three instances (default, no-bypass/no-r0,
// and 8x8) share stimulus; a behavioural model predicts qa/qb/busy per edge.
module tb_regfile_scrub;

  logic        clock;
  logic        reset_n, reset2_n;
  logic        enable, wren, clear_req;
  logic [4:0]  ra, rb, wa;
  logic [31:0] d;
  logic [31:0] qa0, qb0, qa1, qb1;
  logic [7:0]  qa2, qb2;
  logic        busy0, busy1, busy2;

  regfile_scrub dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .rdaddress_a(ra), .rdaddress_b(rb), .wren(wren), .wraddress(wa),
    .data(d), .clear_req(clear_req), .qa(qa0), .qb(qb0), .busy(busy0)
  );

  regfile_scrub #(.ZERO_R0(0), .BYPASS(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .rdaddress_a(ra), .rdaddress_b(rb), .wren(wren), .wraddress(wa),
    .data(d), .clear_req(clear_req), .qa(qa1), .qb(qb1), .busy(busy1)
  );

  regfile_scrub #(.ADDR_W(3), .DATA_W(8)) dut2 (
    .clock(clock), .reset_n(reset2_n), .enable(enable),
    .rdaddress_a(ra[2:0]), .rdaddress_b(rb[2:0]), .wren(wren), .wraddress(wa[2:0]),
    .data(d[7:0]), .clear_req(clear_req), .qa(qa2), .qb(qb2), .busy(busy2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct packed {
    logic [2:0][31:0] qa;
    logic [2:0][31:0] qb;
    logic [2:0]       busy;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Behavioural model: a scrub is "array becomes zero, ports dead for depth edges".
  logic [31:0] mmem [3][32];
  int          mrem [3];
  logic [31:0] mqa  [3];
  logic [31:0] mqb  [3];

  function automatic logic [31:0] mread(input int id, input int a, input int w,
                                        input logic [31:0] dd, input bit byp, input bit zr0);
    if (zr0 && a == 0) return 32'h0;
    if (byp && wren && a == w) return dd;
    return mmem[id][a];
  endfunction

  task automatic model_edge(input int id, input int depth, input bit byp, input bit zr0,
                            input logic [31:0] dmask, input logic rst_n);
    int a, b, w;
    logic [31:0] dd;
    a  = int'(ra) % depth;
    b  = int'(rb) % depth;
    w  = int'(wa) % depth;
    dd = d & dmask;
    if (!rst_n || (mrem[id] == 0 && clear_req)) begin
      mrem[id] = depth;
      mqa[id]  = 32'h0;
      mqb[id]  = 32'h0;
      for (int k = 0; k < 32; k++) mmem[id][k] = 32'h0;
    end else if (mrem[id] > 0) begin
      mrem[id] = mrem[id] - 1;
      mqa[id]  = 32'h0;
      mqb[id]  = 32'h0;
    end else if (enable) begin
      mqa[id] = mread(id, a, w, dd, byp, zr0);
      mqb[id] = mread(id, b, w, dd, byp, zr0);
      if (wren && !(zr0 && w == 0)) mmem[id][w] = dd;
    end
  endtask

  // Predict the coming edge from current inputs, queue it, advance to the next negedge.
  task automatic cycle();
    exp_t e;
    model_edge(0, 32, 1'b1, 1'b1, 32'hFFFF_FFFF, reset_n);
    model_edge(1, 32, 1'b0, 1'b0, 32'hFFFF_FFFF, reset_n);
    model_edge(2, 8,  1'b1, 1'b1, 32'h0000_00FF, reset2_n);
    for (int i = 0; i < 3; i++) begin
      e.qa[i]   = mqa[i];
      e.qb[i]   = mqb[i];
      e.busy[i] = (mrem[i] > 0);
    end
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] got,
                     input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
    end
  endtask

  // Monitor: DUT outputs update every edge; compare against the oldest prediction.
  initial begin : monitor
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cyc++;
        chk("qa0",   cyc, qa0, e.qa[0]);
        chk("qb0",   cyc, qb0, e.qb[0]);
        chk("busy0", cyc, {31'b0, busy0}, {31'b0, e.busy[0]});
        chk("qa1",   cyc, qa1, e.qa[1]);
        chk("qb1",   cyc, qb1, e.qb[1]);
        chk("busy1", cyc, {31'b0, busy1}, {31'b0, e.busy[1]});
        chk("qa2",   cyc, {24'b0, qa2}, e.qa[2]);
        chk("qb2",   cyc, {24'b0, qb2}, e.qb[2]);
        chk("busy2", cyc, {31'b0, busy2}, {31'b0, e.busy[2]});
        $display("cyc %0d busy=%b%b%b qa0=%h qb0=%h qa1=%h qb1=%h qa2=%h qb2=%h",
                 cyc, busy0, busy1, busy2, qa0, qb0, qa1, qb1, qa2, qb2);
      end
    end
  end

  task automatic set_port(input logic en, input logic wr, input logic [4:0] waddr,
                          input logic [31:0] dat, input logic [4:0] a, input logic [4:0] b,
                          input logic clr);
    enable = en; wren = wr; wa = waddr; d = dat; ra = a; rb = b; clear_req = clr;
  endtask

  initial begin : stimulus
    reset_n = 1'b0; reset2_n = 1'b0;
    set_port(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mrem[i] = 0; mqa[i] = 32'h0; mqb[i] = 32'h0;
      for (int k = 0; k < 32; k++) mmem[i][k] = 32'h0;
    end

    // Reset for two edges, then scrub with noisy ports; the small instance is re-reset at scrub edge 4.
    repeat (2) cycle();
    reset_n = 1'b1;
    reset2_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      reset2_n = (i != 4);
      set_port(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
               $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               (i < 13) ? 1'($urandom_range(0, 1)) : 1'b0);
      cycle();
    end
    reset2_n = 1'b1;

    // Every entry reads zero after the scrub.
    for (int i = 0; i < 32; i++) begin
      set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0);
      cycle();
    end

    // Write then read back on both ports.
    set_port(1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0); cycle();
    set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);          cycle();
    // Same-cycle write/read: forwarded vs. prior contents.
    set_port(1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd0, 5'd1, 1'b0);  cycle();
    set_port(1'b1, 1'b1, 5'd9, 32'h1234_5678, 5'd9, 5'd9, 1'b0);  cycle();
    set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0);          cycle();
    // Address 0: plain write, then a read alongside a bypassing write.
    set_port(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd1, 5'd2, 1'b0);  cycle();
    set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);          cycle();
    set_port(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0);  cycle();
    set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);          cycle();

    // Random traffic, including enable=0 holds, forwarding hits and rare clears.
    for (int i = 0; i < 200; i++) begin
      logic [4:0] w;
      w = 5'($urandom_range(0, 31));
      set_port(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), w, $urandom,
               ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31)),
               ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 79) == 0));
      cycle();
    end

    // Let any scrub drain, fill with nonzero data, clear with a colliding write.
    for (int i = 0; i < 40; i++) begin
      set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 1'b0);
      cycle();
    end
    for (int i = 0; i < 32; i++) begin
      set_port(1'b1, 1'b1, 5'(i), $urandom | 32'h0101_0101, 5'(i), 5'(31 - i), 1'b0);
      cycle();
    end
    set_port(1'b1, 1'b1, 5'd3, 32'hCAFE_F00D, 5'd3, 5'd3, 1'b1); cycle();
    for (int j = 1; j <= 32; j++) begin
      set_port(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'(j == 10));
      cycle();
    end
    for (int i = 0; i < 32; i++) begin
      set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b0);
      cycle();
    end
    for (int i = 0; i < 10; i++) begin
      set_port(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i), 1'b0);
      cycle();
    end

    @(posedge clock);
    #2;
    vectors++;
    if (exp_q.size() != 0 || vectors < 100) begin
      miscompares++;
      $display("FAIL scoreboard_drain pending=%0d expected=0 vectors=%0d", exp_q.size(), vectors);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_scrub.md
REGFILE_SCRUB -- requirements
Module: regfile_scrub

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and of the data ports.
REQ-002 Parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_R0, default 1: when 1, entry 0 always reads zero and ignores writes.
REQ-004 Parameter BYPASS, default 1: when 1, a same-cycle write forwards to a matching read.
REQ-005 clock  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 enable  input  1  clock enable for the read and write ports; does not gate the scrub engine.
REQ-008 rdaddress_a  input  ADDR_W  read address, port A.
REQ-009 rdaddress_b  input  ADDR_W  read address, port B.
REQ-010 wren  input  1  write request.
REQ-011 wraddress  input  ADDR_W  write address.
REQ-012 data  input  DATA_W  write data.
REQ-013 clear_req  input  1  request a full scrub of the array to zero.
REQ-014 qa  output  DATA_W  registered read data, port A, one clock delayed.
REQ-015 qb  output  DATA_W  registered read data, port B, one clock delayed.
REQ-016 busy  output  1  scrub in progress; ports inactive.

Function
REQ-017 The block SHALL have two states: SCRUB and IDLE, plus an ADDR_W-bit scrub counter cnt.
REQ-018 In IDLE, with enable=1, it SHALL register qa <= entry(rdaddress_a) and qb <= entry(rdaddress_b); read latency is exactly 1 cycle.
REQ-019 In IDLE, with enable=0, qa/qb and the array SHALL hold.
REQ-020 In IDLE, with enable=1, wren=1 and clear_req=0, it SHALL write data to wraddress at the edge.
REQ-021 With BYPASS=1, a read address equal to wraddress during a write SHALL return the new data. With BYPASS=0, it SHALL return the prior contents.
REQ-022 With ZERO_R0=1, a read of address 0 SHALL return 0 regardless of bypass, and writes to address 0 SHALL be discarded.
REQ-023 Ports A and B reading the same address SHALL both return the same value.
REQ-024 In IDLE, clear_req=1 at an edge SHALL move to SCRUB with cnt<=0 and busy<=1. Any write in that cycle SHALL be dropped, and qa/qb SHALL load 0.
REQ-025 In SCRUB, each edge SHALL write 0 to entry cnt and then increment cnt.
REQ-026 In SCRUB, when cnt==DEPTH-1, that edge SHALL write the final entry, return to IDLE and set busy<=0. cnt SHALL wrap to 0.
REQ-027 A scrub SHALL take exactly DEPTH edges.
REQ-028 While in SCRUB, wren, enable and read addresses SHALL be ignored, qa/qb SHALL be 0, and clear_req SHALL be ignored (no restart).
REQ-029 The first IDLE edge after a scrub completes SHALL accept reads and writes normally.
REQ-030 The array contents SHALL be unaffected by enable=0 only in IDLE; the scrub engine runs regardless of enable.

Reset
REQ-031 At any edge with reset_n=0, the block SHALL set state<=SCRUB, cnt<=0, busy<=1 and qa<=0, qb<=0, and SHALL perform no array write in that cycle.
REQ-032 After reset_n rises, a full scrub SHALL run: busy falls after exactly DEPTH edges with reset_n=1. Afterwards every entry reads 0.
REQ-033 reset_n=0 during a scrub or a normal operation SHALL abort it and restart the scrub from cnt=0 per REQ-031.
REQ-034 reset_n SHALL take priority over clear_req, wren and enable.

Verification
REQ-035 Scenario: defaults; hold reset_n=0 for 2 edges, then release. Required: busy=1 for 32 edges, then 0; reads of all 32 addresses return 0x00000000.
REQ-036 Scenario: write 0xDEADBEEF to address 7, then read A=7 and B=7 on the next cycle. Required: qa=qb=0xDEADBEEF one cycle later.
REQ-037 Scenario: same cycle wren=1, wraddress=9, data=0x12345678, rdaddress_a=9. Required: qa=0x12345678 with BYPASS=1; qa equals the old value with BYPASS=0.
REQ-038 Scenario: ZERO_R0=1; write 0xFFFFFFFF to address 0, and separately read address 0 with a bypassing write to address 0. Required: qa=0 in both cases.
REQ-039 Scenario: fill all entries with nonzero data, pulse clear_req with wren=1 to address 3, then assert clear_req again at scrub edge 10. Required: busy=1 for exactly 32 edges (no restart), the write is dropped, and all entries read 0.
REQ-040 Scenario: ADDR_W=3, DATA_W=8; assert reset_n=0 at scrub edge 4, then release. Required: the scrub restarts and busy falls exactly 8 edges after release.
